regfile_alu_seq: RTL and testbench

REGFILE_ALU_SEQ -- requirements
Module: regfile_alu_seq

---
 rtl/regfile_alu_seq.sv | 173 +++++++++++++++++
 tb/tb_regfile_alu_seq.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_alu_seq.sv
// rtl/regfile_alu_seq.sv - pushbutton-driven register file with a three-phase ALU sequencer
module regfile_alu_seq #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16,  // power of two
  parameter int SW_W  = 10   // must cover two register addresses and op+mode
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SW_W-1:0]  sw,
  input  logic             btn_reg_n,
  input  logic             btn_setup_n,
  input  logic             btn_imm_n,
  input  logic             btn_step_n,
  output logic [4:0]       flags,
  output logic [WIDTH-1:0] rdest_out,
  output logic             busy
);
  localparam int AW = $clog2(NREGS);
  // flag bit positions inside {C, L, F, Z, N}
  localparam int FC = 4;
  localparam int FL = 3;
  localparam int FF = 2;
  localparam int FZ = 1;
  localparam int FN = 0;

  typedef enum logic [1:0] {IDLE, EXEC, WRITE} state_t;

  // button order everywhere: {reg, setup, imm, step}, i.e. highest priority first
  logic [3:0] btn_n, sync1_q, sync2_q, prev_q, pulse;

  state_t state_q, state_d;
  logic   ld_reg, ld_setup, ld_imm;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [AW-1:0]    rdest_q, rsrc_q;
  logic [3:0]       op_q;
  logic             imm_mode_q;
  logic [WIDTH-1:0] imm_q;
  logic [4:0]       flags_q;

  logic [WIDTH-1:0] result_d, result_q;
  logic [4:0]       flags_d, flags_nx_q;
  logic             wr_d, wr_q, upd_d, upd_q;

  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH:0]   sum, diff;
  logic [3:0]       shamt;

  assign btn_n = {btn_reg_n, btn_setup_n, btn_imm_n, btn_step_n};
  // stages reset to 0 so a button held through reset looks already pressed
  assign pulse = prev_q & ~sync2_q;

  // synchronize the raw buttons and keep one extra stage for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // sequencer state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state and load strobes; only one press per cycle is honoured, and only in IDLE
  always_comb begin
    state_d  = state_q;
    ld_reg   = 1'b0;
    ld_setup = 1'b0;
    ld_imm   = 1'b0;
    case (state_q)
      IDLE: begin
        if      (pulse[3]) ld_reg   = 1'b1;
        else if (pulse[2]) ld_setup = 1'b1;
        else if (pulse[1]) ld_imm   = 1'b1;
        else if (pulse[0]) state_d  = EXEC;
      end
      EXEC:    state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign op_a  = regs_q[rdest_q];
  assign op_b  = imm_mode_q ? imm_q : regs_q[rsrc_q];
  assign sum   = {1'b0, op_a} + {1'b0, op_b};
  assign diff  = {1'b0, op_a} - {1'b0, op_b};
  assign shamt = op_b[3:0];

  // ALU: result, write enable and candidate flags; C/L/F hold unless the op defines them
  always_comb begin
    result_d = '0;
    flags_d  = flags_q;
    wr_d     = 1'b1;
    upd_d    = 1'b1;
    case (op_q)
      4'd0: begin
        result_d    = sum[WIDTH-1:0];
        flags_d[FC] = sum[WIDTH];
        flags_d[FF] = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      4'd1, 4'd5: begin
        result_d    = diff[WIDTH-1:0];
        flags_d[FC] = diff[WIDTH];
        flags_d[FL] = diff[WIDTH];
        flags_d[FF] = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
        wr_d        = (op_q == 4'd1);
      end
      4'd2:    result_d = op_a & op_b;
      4'd3:    result_d = op_a | op_b;
      4'd4:    result_d = op_a ^ op_b;
      4'd6:    result_d = op_b;
      4'd7:    result_d = op_a << shamt;
      4'd8:    result_d = op_a >> shamt;
      default: begin
        wr_d  = 1'b0;
        upd_d = 1'b0;
      end
    endcase
    if (upd_d) begin
      flags_d[FZ] = (result_d == '0);
      flags_d[FN] = result_d[WIDTH-1];
    end
  end

  // operand/config loads, EXEC capture and WRITE commit
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      rdest_q    <= '0;
      rsrc_q     <= '0;
      op_q       <= 4'hF;
      imm_mode_q <= 1'b0;
      imm_q      <= '0;
      flags_q    <= '0;
      result_q   <= '0;
      flags_nx_q <= '0;
      wr_q       <= 1'b0;
      upd_q      <= 1'b0;
    end else begin
      if (ld_reg) begin
        rdest_q <= sw[AW-1:0];
        rsrc_q  <= sw[2*AW-1:AW];
      end
      if (ld_setup) begin
        op_q       <= sw[3:0];
        imm_mode_q <= sw[4];
      end
      if (ld_imm) imm_q <= WIDTH'(sw);
      if (state_q == EXEC) begin
        result_q   <= result_d;
        flags_nx_q <= flags_d;
        wr_q       <= wr_d;
        upd_q      <= upd_d;
      end
      if (state_q == WRITE) begin
        if (wr_q)  regs_q[rdest_q] <= result_q;
        if (upd_q) flags_q         <= flags_nx_q;
      end
    end
  end

  assign flags     = flags_q;
  assign rdest_out = regs_q[rdest_q];
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_regfile_alu_seq.sv
// tb/tb_regfile_alu_seq.sv - random and directed checks of two regfile_alu_seq configurations
module tb_regfile_alu_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [9:0]  sw16;
  logic [5:0]  sw8;
  logic [3:0]  btn_n;  // {reg, setup, imm, step}
  logic [4:0]  flags16, flags8;
  logic [15:0] rout16;
  logic [7:0]  rout8;
  logic        busy16, busy8;

  regfile_alu_seq dut16 (
    .clk(clk), .reset(reset), .sw(sw16),
    .btn_reg_n(btn_n[3]), .btn_setup_n(btn_n[2]), .btn_imm_n(btn_n[1]), .btn_step_n(btn_n[0]),
    .flags(flags16), .rdest_out(rout16), .busy(busy16)
  );

  regfile_alu_seq #(.WIDTH(8), .NREGS(4), .SW_W(6)) dut8 (
    .clk(clk), .reset(reset), .sw(sw8),
    .btn_reg_n(btn_n[3]), .btn_setup_n(btn_n[2]), .btn_imm_n(btn_n[1]), .btn_step_n(btn_n[0]),
    .flags(flags8), .rdest_out(rout8), .busy(busy8)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 0;
  int busy_cycles = 0;

  // reference model, index 0 = 16-bit unit, 1 = 8-bit unit
  int              wv [2] = '{16, 8};
  int              awv[2] = '{4, 2};
  longint unsigned m_r  [2][16];
  int              m_rd [2], m_rs[2], m_op[2], m_cnt[2];
  bit              m_im [2];
  longint unsigned m_imm[2];
  bit [4:0]        m_fl [2];
  bit [3:0]        h1[2], h2[2], h3[2];  // button levels sampled 1, 2, 3 edges ago

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit msb(input longint unsigned x, input int u);
    return ((x >> (wv[u] - 1)) & 64'd1) != 0;
  endfunction

  task automatic commit(input int u);
    longint unsigned a, b, r, mk;
    bit wr, up;
    bit [4:0] f;
    mk = (64'd1 << wv[u]) - 1;
    a  = m_r[u][m_rd[u]];
    b  = m_im[u] ? m_imm[u] : m_r[u][m_rs[u]];
    f  = m_fl[u];
    wr = 1; up = 1; r = 0;
    case (m_op[u])
      0: begin
        r    = (a + b) & mk;
        f[4] = ((a + b) >> wv[u]) != 0;
        f[2] = (msb(a, u) == msb(b, u)) && (msb(r, u) != msb(a, u));
      end
      1, 5: begin
        r    = (a - b) & mk;
        f[4] = a < b;
        f[3] = a < b;
        f[2] = (msb(a, u) != msb(b, u)) && (msb(r, u) != msb(a, u));
        wr   = (m_op[u] == 1);
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      6: r = b;
      7: r = (a << (b & 15)) & mk;
      8: r = a >> (b & 15);
      default: begin wr = 0; up = 0; end
    endcase
    if (up) begin
      f[1] = (r == 0);
      f[0] = msb(r, u);
      m_fl[u] = f;
    end
    if (wr) m_r[u][m_rd[u]] = r;
  endtask

  // one clock edge of the model: a press is a 1->0 step of the sampled button,
  // acted on three edges after the first low sample
  task automatic model_edge(input int u, input bit rst, input longint unsigned swv, input bit [3:0] bn);
    bit [3:0] pr;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_r[u][i] = 0;
      m_rd[u] = 0; m_rs[u] = 0; m_op[u] = 15; m_im[u] = 0; m_imm[u] = 0;
      m_fl[u] = 0; m_cnt[u] = 0; h1[u] = 0; h2[u] = 0; h3[u] = 0;
      return;
    end
    pr = h3[u] & ~h2[u];
    if (m_cnt[u] > 0) begin
      m_cnt[u]--;
      if (m_cnt[u] == 0) commit(u);
    end else if (pr[3]) begin
      m_rd[u] = int'(swv & ((64'd1 << awv[u]) - 1));
      m_rs[u] = int'((swv >> awv[u]) & ((64'd1 << awv[u]) - 1));
    end else if (pr[2]) begin
      m_op[u] = int'(swv & 15);
      m_im[u] = ((swv >> 4) & 1) != 0;
    end else if (pr[1]) begin
      m_imm[u] = swv;
    end else if (pr[0]) begin
      m_cnt[u] = 2;
    end
    h3[u] = h2[u]; h2[u] = h1[u]; h1[u] = bn;
  endtask

  always @(posedge clk) begin
    model_edge(0, reset, 64'(sw16), btn_n);
    model_edge(1, reset, 64'(sw8), btn_n);
  end

  // per-cycle comparison of both units against the model
  always @(negedge clk) begin
    if (chk_on) begin
      check("busy16",  64'(busy16),  64'(m_cnt[0] > 0));
      check("rdest16", 64'(rout16),  m_r[0][m_rd[0]]);
      check("flags16", 64'(flags16), 64'(m_fl[0]));
      check("busy8",   64'(busy8),   64'(m_cnt[1] > 0));
      check("rdest8",  64'(rout8),   m_r[1][m_rd[1]]);
      check("flags8",  64'(flags8),  64'(m_fl[1]));
    end
  end

  always @(negedge clk) if (busy16) busy_cycles++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] m, input logic [9:0] s16, input logic [5:0] s8);
    sw16 = s16; sw8 = s8;
    btn_n = ~m;
    tick(2);
    btn_n = 4'hF;
    tick(6);
  endtask

  task automatic step_op(input logic [9:0] setup16, input logic [5:0] setup8,
                         input logic [9:0] imm16, input logic [5:0] imm8);
    press(4'b0100, setup16, setup8);
    press(4'b0010, imm16, imm8);
    press(4'b0001, 10'd0, 6'd0);
  endtask

  int b0;
  int n_hold, n_rel;
  logic [3:0] m;
  logic [9:0] s;

  initial begin
    reset = 1'b1; btn_n = 4'hF; sw16 = '0; sw8 = '0;
    tick(3);
    reset = 1'b0;
    chk_on = 1;
    @(negedge clk);
    check("rst_rout", 64'(rout16), 64'h0);
    check("rst_flags", 64'(flags16), 64'h0);
    check("rst_busy", 64'(busy16), 64'h0);
    tick(1);

    // R0 <- 8 via immediate; busy for exactly two cycles
    press(4'b1000, 10'h000, 6'h00);
    press(4'b0100, 10'h016, 6'h16);
    press(4'b0010, 10'h008, 6'h08);
    b0 = busy_cycles;
    press(4'b0001, 10'h000, 6'h00);
    @(negedge clk);
    check("r038_r0_16", 64'(rout16), 64'h0008);
    check("r038_fl_16", 64'(flags16), 64'h00);
    check("r038_busy_len", 64'(busy_cycles - b0), 64'd2);
    check("r038_r0_8", 64'(rout8), 64'h08);
    check("r038_fl_8", 64'(flags8), 64'h00);
    tick(1);

    // build 0x7FFF / 0x7F, then add 1 to force signed overflow
    step_op(10'h016, 6'h16, 10'd1, 6'd1);    // MOV 1
    step_op(10'h017, 6'h17, 10'd15, 6'd7);   // LSH to MSB
    step_op(10'h011, 6'h11, 10'd1, 6'd1);    // SUB 1
    check("r039_pre_16", 64'(rout16), 64'h7FFF);
    step_op(10'h010, 6'h10, 10'd1, 6'd1);    // ADD 1
    @(negedge clk);
    check("r039_r0_16", 64'(rout16), 64'h8000);
    check("r039_fl_16", 64'(flags16), 64'b00101);
    check("r039_r0_8", 64'(rout8), 64'h80);
    check("r039_fl_8", 64'(flags8), 64'b00101);
    tick(1);

    // R1=3, R2=5, CMP R1,R2 in register mode
    press(4'b1000, 10'h001, 6'h01);
    step_op(10'h016, 6'h16, 10'd3, 6'd3);
    press(4'b1000, 10'h002, 6'h02);
    step_op(10'h016, 6'h16, 10'd5, 6'd5);
    press(4'b1000, 10'h021, 6'h09);
    press(4'b0100, 10'h005, 6'h05);
    press(4'b0001, 10'h000, 6'h00);
    @(negedge clk);
    check("r040_r1_16", 64'(rout16), 64'h0003);
    check("r040_fl_16", 64'(flags16), 64'b11001);
    check("r040_r1_8", 64'(rout8), 64'h03);
    check("r040_fl_8", 64'(flags8), 64'b11001);
    tick(1);

    // all four buttons together: only the register load happens
    press(4'b0100, 10'h010, 6'h10);
    press(4'b0010, 10'h001, 6'h01);
    b0 = busy_cycles;
    press(4'b1111, 10'h002, 6'h02);
    @(negedge clk);
    check("r041_noexec", 64'(busy_cycles - b0), 64'd0);
    check("r041_rsel", 64'(rout16), 64'h0005);
    tick(1);
    // step, then a reg press landing in EXEC and a second step landing in WRITE
    b0 = busy_cycles;
    sw16 = 10'h001; sw8 = 6'h01;
    btn_n = 4'b1110; tick(1);
    btn_n = 4'b0111; tick(1);
    btn_n = 4'b0110; tick(2);
    btn_n = 4'hF;    tick(8);
    @(negedge clk);
    check("r041_onewrite", 64'(rout16), 64'h0006);
    check("r041_busy_len", 64'(busy_cycles - b0), 64'd2);
    tick(1);

    // setup held low through reset must not register as a press
    sw16 = 10'h016; sw8 = 6'h16;
    btn_n = 4'b1011;
    reset = 1'b1; tick(2);
    reset = 1'b0; tick(4);
    btn_n = 4'hF; tick(4);
    press(4'b0010, 10'd5, 6'd5);
    press(4'b0001, 10'd0, 6'd0);
    @(negedge clk);
    check("r037_nopulse", 64'(rout16), 64'h0);
    tick(1);

    // reset lands on the WRITE cycle of a SUB
    press(4'b0100, 10'h011, 6'h11);
    press(4'b0010, 10'd3, 6'd3);
    btn_n = 4'b1110; tick(1);
    btn_n = 4'hF;    tick(3);
    @(negedge clk);
    check("r042_inwrite", 64'(busy16), 64'd1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    check("r042_rout", 64'(rout16), 64'h0);
    check("r042_flags", 64'(flags16), 64'h0);
    check("r042_busy", 64'(busy16), 64'h0);
    tick(1);

    // randomized presses, overlaps, re-presses and occasional resets
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 99) < 3) begin
        reset = 1'b1;
        tick($urandom_range(1, 2));
        reset = 1'b0;
      end
      m = 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) m = m | 4'($urandom_range(0, 15));
      s = 10'($urandom_range(0, 1023));
      if (m[2] && $urandom_range(0, 1) == 1) s[3:0] = 4'($urandom_range(0, 8));
      sw16 = s; sw8 = s[5:0];
      n_hold = $urandom_range(1, 4);
      n_rel  = $urandom_range(1, 6);
      btn_n = ~m;
      tick(n_hold);
      btn_n = 4'hF;
      tick(n_rel);
    end
    tick(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
